// File: rtl/dm_mem_responder.sv
// ============================================================================
// Module      : dm_mem_responder
// Description : Memory-side responder for the L1 D-cache request port. It
//               serves single-word reads, 4-beat line reads and byte-strobed
//               writes from a local word array, with programmable latency.
//               The optional macro DM_MEM_RESP_STATS_EN adds read and write
//               accept counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dm_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        burst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb_n,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        mem_wait
`ifdef DM_MEM_RESP_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAT     = 3'd1,
    ST_BEAT    = 3'd2,
    ST_WCOMMIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_q,   state_d;
  logic                is_rd_q,   is_rd_d;
  logic                burst_q,   burst_d;
  logic [ADDR_W-1:0]   idx_q,     idx_d;
  logic [31:0]         wdata_q,   wdata_d;
  logic [3:0]          wstrb_n_q, wstrb_n_d;
  logic [1:0]          beat_q,    beat_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;

  logic [31:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   rd_idx;
  logic                wr_pending;
  logic                idle_like;

  // Only the word-index bits of the address select storage; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign wr_pending = (wstrb_n != 4'hF);

  // Any encoding outside the four busy states behaves as IDLE.
  always_comb begin
    idle_like = 1'b1;
    case (state_q)
      ST_LAT, ST_BEAT, ST_WCOMMIT, ST_DONE: idle_like = 1'b0;
      default:                             idle_like = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wstrb_n_d = wstrb_n_q;
    beat_d    = beat_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_LAT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d = is_rd_q ? ST_BEAT : ST_WCOMMIT;
        end
      end
      ST_BEAT: begin
        beat_d = beat_q + 2'd1;
        if (!burst_q || (beat_q == 2'd3)) begin
          state_d = ST_DONE;
        end
      end
      ST_WCOMMIT: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default: begin
        // A read wins over a simultaneous write strobe; the write is dropped.
        if (req || wr_pending) begin
          is_rd_d   = req;
          burst_d   = burst;
          idx_d     = addr[ADDR_W+1:2];
          wdata_d   = wdata;
          wstrb_n_d = wstrb_n;
          beat_d    = 2'd0;
          lat_cnt_d = LAT_INIT;
          if (LATENCY > 0) begin
            state_d = ST_LAT;
          end else begin
            state_d = req ? ST_BEAT : ST_WCOMMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      is_rd_q   <= 1'b0;
      burst_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_n_q <= 4'hF;
      beat_q    <= 2'd0;
      lat_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wstrb_n_q <= wstrb_n_d;
      beat_q    <= beat_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Storage is deliberately not reset; reset only blocks a commit on its edge.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_WCOMMIT)) begin
      for (int b = 0; b < 4; b++) begin
        if (!wstrb_n_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Bursts walk the line from its base and wrap inside it.
  assign rd_idx = burst_q ? {idx_q[ADDR_W-1:2], beat_q} : idx_q;
  assign rvalid = (state_q == ST_BEAT);
  assign rdata  = rvalid ? mem_q[rd_idx] : 32'h0;

  always_comb begin
    mem_wait = 1'b0;
    case (state_q)
      ST_LAT, ST_BEAT, ST_WCOMMIT: mem_wait = 1'b1;
      ST_DONE:                     mem_wait = 1'b0;
      default:                     mem_wait = req || wr_pending;
    endcase
  end

`ifdef DM_MEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (idle_like && req) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else if (idle_like && wr_pending) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  logic unused_idle_like;
  assign unused_idle_like = idle_like;
`endif

endmodule

`default_nettype wire
